// File: rtl/serial_adder.sv
`default_nettype none
// =============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder, one full-adder cell plus carry flop,
//            LSB first, one bit per clock, one-cycle done pulse.
// Revision : 1.0 - initial release
// =============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_shift = 2'd1;
   localparam logic [1:0] c_done  = 2'd2;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [WIDTH-1:0] r_res;
   logic [CNT_W-1:0] r_cnt;

   logic             w_sum;
   logic             w_carry_next;
   logic [WIDTH-1:0] w_res_shift;

   // Full-adder bit cell fed from the LSBs of the operand shift registers.
   assign w_sum        = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

   generate
      if (WIDTH == 1) begin : g_single_bit
         assign w_res_shift = w_sum;
      end else begin : g_multi_bit
         assign w_res_shift = {w_sum, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_res   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            c_idle, c_done: begin
               // DONE shares the accept path so back-to-back starts lose no cycle.
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_carry <= Cin;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_state <= c_shift;
               end else begin
                  r_state <= c_idle;
               end
            end
            c_shift: begin
               r_carry <= w_carry_next;
               r_res   <= w_res_shift;
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + c_one;
               if (r_cnt == c_last) begin
                  r_state <= c_done;
               end
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   assign busy = (r_state == c_shift);
   assign done = (r_state == c_done);
   assign S    = r_res;
   assign Cout = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// =============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder at WIDTH 8, 1, 32.
// Revision : 1.0 - initial release
// =============================================================================
module tb_serial_adder;

   logic clk;
   logic rst_n;

   logic        start8, cin8, busy8, done8, cout8;
   logic [7:0]  a8, b8, s8;
   logic        start1, cin1, busy1, done1, cout1;
   logic [0:0]  a1, b1, s1;
   logic        start32, cin32, busy32, done32, cout32;
   logic [31:0] a32, b32, s32;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
      .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
      .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
   );

   serial_adder #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .A(a32), .B(b32), .Cin(cin32),
      .busy(busy32), .done(done32), .S(s32), .Cout(cout32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present operands for one edge, then scramble them to prove capture.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
   endtask

   // Counts edges after the accept edge until done is seen at a negedge.
   task automatic wait8(output int cyc, output int bcnt);
      bit seen;
      seen = 1'b0; cyc = 0; bcnt = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (done8) seen = 1'b1;
         else begin
            if (busy8) bcnt++;
            @(posedge clk);
            cyc++;
         end
      end
      chk_eq("w8_timeout", 64'(seen), 64'd1);
   endtask

   task automatic check_result8(input string tag, input logic [8:0] exp);
      chk_eq({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
      chk_eq({tag, "_S"},    64'(s8),   64'(exp[7:0]));
      chk_eq({tag, "_Cout"}, 64'(cout8), 64'(exp[8]));
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [8:0] exp);
      int cyc, bcnt;
      issue8(a, b, c);
      wait8(cyc, bcnt);
      chk_eq({tag, "_latency"}, 64'(cyc), 64'd8);
      chk_eq({tag, "_busy_cycles"}, 64'(bcnt), 64'd8);
      check_result8(tag, exp);
   endtask

   task automatic run1(input logic a, input logic b, input logic c, input logic [1:0] exp);
      @(negedge clk);
      start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      @(posedge clk);
      #1;
      start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
      @(negedge clk);
      chk_eq("w1_busy", 64'({busy1, done1}), 64'b10);
      @(negedge clk);
      chk_eq("w1_done", 64'({busy1, done1}), 64'b01);
      chk_eq("w1_sum", 64'({cout1, s1}), 64'(exp));
      @(negedge clk);
      chk_eq("w1_idle", 64'({busy1, done1}), 64'b00);
   endtask

   task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [32:0] exp);
      bit seen;
      int cyc;
      @(negedge clk);
      start32 = 1'b1; a32 = a; b32 = b; cin32 = c;
      @(posedge clk);
      #1;
      start32 = 1'b0; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
      seen = 1'b0; cyc = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done32) seen = 1'b1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      chk_eq("w32_timeout", 64'(seen), 64'd1);
      chk_eq("w32_latency", 64'(cyc), 64'd32);
      chk_eq("w32_sum", 64'({cout32, s32}), 64'(exp));
   endtask

   initial begin
      int cyc, bcnt;
      logic [7:0]  ra, rb;
      logic        rc;
      logic [31:0] qa, qb;

      rst_n = 1'b0;
      start8 = 0;  a8 = '0;  b8 = '0;  cin8 = 0;
      start1 = 0;  a1 = '0;  b1 = '0;  cin1 = 0;
      start32 = 0; a32 = '0; b32 = '0; cin32 = 0;
      repeat (2) @(negedge clk);
      chk_eq("reset_w8", 64'({busy8, done8, cout8, s8}), 64'd0);
      chk_eq("reset_w1", 64'({busy1, done1, cout1, s1}), 64'd0);
      chk_eq("reset_w32", 64'({busy32, done32, cout32, s32}), 64'd0);
      rst_n = 1'b1;

      // Basic add, result held in IDLE afterwards.
      run8("t1", 8'h3C, 8'h0F, 1'b0, 9'h04B);
      @(negedge clk);
      chk_eq("t1_done_one_cycle", 64'(done8), 64'd0);
      chk_eq("t1_hold_S", 64'(s8), 64'h4B);
      repeat (3) @(negedge clk);
      chk_eq("t1_hold_S_later", 64'({busy8, cout8, s8}), 64'h04B);

      // Carry propagation across the full width.
      run8("t2a", 8'hFF, 8'h01, 1'b0, 9'h100);
      run8("t2b", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

      // Start during SHIFT is ignored.
      issue8(8'h12, 8'h34, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
      wait8(cyc, bcnt);
      chk_eq("t3_latency", 64'(cyc), 64'd5);
      check_result8("t3", 9'h046);
      @(negedge clk);
      chk_eq("t3_no_queue", 64'({busy8, done8}), 64'd0);

      // Asynchronous reset mid-operation.
      issue8(8'h80, 8'h80, 1'b1);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("t4_async_reset", 64'({busy8, done8, cout8, s8}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("t4_after_reset", 64'({busy8, done8, cout8, s8}), 64'd0);
      run8("t4", 8'h01, 8'h02, 1'b0, 9'h003);

      // start held high: back-to-back operations.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
      @(posedge clk);
      #1;
      a8 = 8'hE3; b8 = 8'h5A; cin8 = 1'b1;
      wait8(cyc, bcnt);
      chk_eq("t5a_latency", 64'(cyc), 64'd8);
      check_result8("t5a", 9'h030);
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
      @(posedge clk);
      #1;
      a8 = 8'h3C; b8 = 8'hC3; cin8 = 1'b1;
      wait8(cyc, bcnt);
      chk_eq("t5b_latency", 64'(cyc), 64'd8);
      chk_eq("t5b_busy_cycles", 64'(bcnt), 64'd8);
      check_result8("t5b", 9'h080);
      start8 = 1'b0;
      @(negedge clk);
      chk_eq("t5_idle", 64'({busy8, done8}), 64'd0);

      // WIDTH=1 truth table.
      run1(1'b0, 1'b0, 1'b0, 2'b00);
      run1(1'b1, 1'b0, 1'b0, 2'b01);
      run1(1'b0, 1'b1, 1'b1, 2'b10);
      run1(1'b1, 1'b1, 1'b0, 2'b10);
      run1(1'b1, 1'b1, 1'b1, 2'b11);
      run1(1'b0, 1'b0, 1'b1, 2'b01);

      // WIDTH=32 directed vectors.
      run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
      run32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 33'h0_ACF1_3569);
      run32(32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001);

      // Random operands at WIDTH=8 and 32 with random idle gaps.
      for (int k = 0; k < 100; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run8("rnd8", ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
      end
      for (int k = 0; k < 30; k++) begin
         qa = $urandom; qb = $urandom; rc = 1'($urandom);
         run32(qa, qb, rc, 33'(qa) + 33'(qb) + 33'(rc));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
